// File: rtl/adc_cal_pkg.sv
// Shared types and helpers for the ADC IDELAY calibration sequencer.
package adc_cal_pkg;

  localparam int NLANES = 28;
  localparam int NTAPS  = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_SETTLE, S_CHECK, S_STEP, S_EVAL, S_APPLY, S_DONE
  } cal_state_e;

  typedef struct packed {
    logic [1:0] ch;
    logic [2:0] lbit;
  } lane_loc_t;

  // Lane 7c+b lives on channel c, bit pair b.
  function automatic lane_loc_t lane_loc(input int lane);
    lane_loc_t loc;
    loc.ch   = 2'(lane / 7);
    loc.lbit = 3'(lane % 7);
    return loc;
  endfunction

  function automatic logic [13:0] raw_code(input logic [13:0] word);
    return {word[13], ~word[12:0]};
  endfunction

endpackage

// File: rtl/adc_cal_window_finder.sv
// Sequential longest-run scanner over one 32-tap pass map; one tap per cycle,
// lowest start wins on ties, runs do not wrap from tap 31 to tap 0.
module adc_cal_window_finder
  import adc_cal_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NTAPS-1:0] map_i,
  output logic             done_o,
  output logic [4:0]       start_o,
  output logic [5:0]       len_o,
  output logic [4:0]       center_o
);

  logic [NTAPS-1:0] map_q, map_d;
  logic [4:0]       idx_q, idx_d, run_start_q, run_start_d, best_start_q, best_start_d;
  logic [5:0]       run_len_q, run_len_d, best_len_q, best_len_d;
  logic             busy_q, busy_d, done_q, done_d;

  always_comb begin
    map_d        = map_q;
    idx_d        = idx_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    if (start_i) begin
      map_d        = map_i;
      idx_d        = '0;
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
      busy_d       = 1'b1;
    end else if (busy_q) begin
      if (map_q[idx_q]) begin
        run_len_d   = run_len_q + 6'd1;
        run_start_d = (run_len_q == 6'd0) ? idx_q : run_start_q;
        // Strict compare keeps the earliest run when lengths tie.
        if (run_len_d > best_len_q) begin
          best_len_d   = run_len_d;
          best_start_d = run_start_d;
        end
      end else begin
        run_len_d = '0;
      end
      idx_d = idx_q + 5'd1;
      if (idx_q == 5'(NTAPS - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      map_q        <= '0;
      idx_q        <= '0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      map_q        <= map_d;
      idx_q        <= idx_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign done_o   = done_q;
  assign start_o  = best_start_q;
  assign len_o    = best_len_q;
  assign center_o = best_start_q + 5'((best_len_q - 6'd1) >> 1);

endmodule

// File: rtl/axis_adc_idelay_cal.sv
// IDELAY calibration sequencer: sweeps all 28 lanes through 32 taps, then
// steps each lane to the centre of its longest passing window.
//   state    | meaning                    state   | meaning
//   IDLE     | waiting for start          STEP    | one all-lanes CE beat
//   WAIT_RDY | wait for IDELAYCTRL        EVAL    | window search per lane
//   SETTLE   | let the new tap settle     APPLY   | CE beats toward centre
//   CHECK    | compare valid samples      DONE    | results held
module axis_adc_idelay_cal
  import adc_cal_pkg::*;
#(
  parameter int INIT_TAP      = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 64,
  parameter int MIN_WINDOW    = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic [13:0] pattern,
  input  logic        idelay_ctrl_rdy,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic [27:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic        done,
  output logic        fail,
  input  logic [4:0]  sts_lane,
  output logic [4:0]  sts_tap,
  output logic [5:0]  sts_width
);

  cal_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  shadow_q, shadow_d, lane_q, lane_d;
  logic [5:0]  nbeat_q, nbeat_d;
  logic        mtvalid_q, mtvalid_d, done_q, done_d, fail_q, fail_d, wf_start_q, wf_start_d;
  logic [27:0] mtdata_q, mtdata_d, mism_q, mism_d;
  logic        pass_we, rec_we, dec_en;

  logic [31:0] pass_q  [NLANES];
  logic [4:0]  delta_q [NLANES];
  logic [4:0]  tap_q   [NLANES];
  logic [5:0]  width_q [NLANES];
  logic [4:0]  sts_tap_q;
  logic [5:0]  sts_width_q;

  logic [13:0] raw_ch [4];
  logic [27:0] sample_mm, apply_mask;
  logic        wf_done;
  logic [4:0]  wf_center, wf_start_unused, rec_delta, rec_tap;
  logic [5:0]  wf_len;
  logic        unused_bits;

  for (genvar c = 0; c < 4; c++) begin : g_ch
    assign raw_ch[c] = raw_code(s_axis_tdata[16*c +: 14]);
  end

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    localparam lane_loc_t LOC = lane_loc(l);
    assign sample_mm[l]  = raw_ch[LOC.ch][2*LOC.lbit +: 2] != pattern[2*LOC.lbit +: 2];
    assign apply_mask[l] = delta_q[l] != 5'd0;
  end

  assign unused_bits = ^{s_axis_tdata[63:62], s_axis_tdata[47:46],
                         s_axis_tdata[31:30], s_axis_tdata[15:14], wf_start_unused};

  adc_cal_window_finder u_finder (
    .clk      (aclk),
    .rst      (areset),
    .start_i  (wf_start_q),
    .map_i    (pass_q[lane_q]),
    .done_o   (wf_done),
    .start_o  (wf_start_unused),
    .len_o    (wf_len),
    .center_o (wf_center)
  );

  // An empty window leaves the lane parked at its reset tap.
  assign rec_delta = (wf_len == 6'd0) ? 5'd0 : wf_center - 5'(INIT_TAP);
  assign rec_tap   = (wf_len == 6'd0) ? 5'(INIT_TAP) : wf_center;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    lane_d     = lane_q;
    nbeat_d    = nbeat_q;
    mtvalid_d  = mtvalid_q;
    mtdata_d   = mtdata_q;
    done_d     = done_q;
    fail_d     = fail_q;
    mism_d     = mism_q;
    wf_start_d = 1'b0;
    pass_we    = 1'b0;
    rec_we     = 1'b0;
    dec_en     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d  = S_WAIT_RDY;
        shadow_d = 5'(INIT_TAP);
        nbeat_d  = '0;
        done_d   = 1'b0;
        fail_d   = 1'b0;
      end
      S_WAIT_RDY: if (idelay_ctrl_rdy) begin
        state_d = S_SETTLE;
        cnt_d   = 8'(SETTLE_CYCLES - 1);
      end
      S_SETTLE: if (cnt_q == 8'd0) begin
        state_d = S_CHECK;
        cnt_d   = 8'(SAMPLE_CYCLES - 1);
        mism_d  = '0;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      S_CHECK: if (s_axis_tvalid) begin
        mism_d = mism_q | sample_mm;
        if (cnt_q == 8'd0) begin
          pass_we   = 1'b1;
          state_d   = S_STEP;
          mtvalid_d = 1'b1;
          mtdata_d  = '1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_STEP: if (mtvalid_q && m_axis_tready) begin
        mtvalid_d = 1'b0;
        mtdata_d  = '0;
        shadow_d  = shadow_q + 5'd1;
        nbeat_d   = nbeat_q + 6'd1;
        if (nbeat_q == 6'(NTAPS - 1)) begin
          state_d    = S_EVAL;
          lane_d     = '0;
          wf_start_d = 1'b1;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = 8'(SETTLE_CYCLES - 1);
        end
      end
      S_EVAL: if (wf_done) begin
        rec_we = 1'b1;
        if (wf_len < 6'(MIN_WINDOW)) fail_d = 1'b1;
        if (lane_q == 5'(NLANES - 1)) begin
          state_d = S_APPLY;
        end else begin
          lane_d     = lane_q + 5'd1;
          wf_start_d = 1'b1;
        end
      end
      S_APPLY: if (mtvalid_q) begin
        if (m_axis_tready) begin
          dec_en    = 1'b1;
          mtvalid_d = 1'b0;
          mtdata_d  = '0;
        end
      end else if (apply_mask == '0) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        mtvalid_d = 1'b1;
        mtdata_d  = apply_mask;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      lane_q     <= '0;
      nbeat_q    <= '0;
      mtvalid_q  <= 1'b0;
      mtdata_q   <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      mism_q     <= '0;
      wf_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      lane_q     <= lane_d;
      nbeat_q    <= nbeat_d;
      mtvalid_q  <= mtvalid_d;
      mtdata_q   <= mtdata_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      mism_q     <= mism_d;
      wf_start_q <= wf_start_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int l = 0; l < NLANES; l++) begin
        pass_q[l]  <= '0;
        delta_q[l] <= '0;
        tap_q[l]   <= '0;
        width_q[l] <= '0;
      end
      sts_tap_q   <= '0;
      sts_width_q <= '0;
    end else begin
      if (pass_we) begin
        for (int l = 0; l < NLANES; l++) pass_q[l][shadow_q] <= ~mism_d[l];
      end
      if (rec_we) begin
        delta_q[lane_q] <= rec_delta;
        tap_q[lane_q]   <= rec_tap;
        width_q[lane_q] <= wf_len;
      end
      if (dec_en) begin
        for (int l = 0; l < NLANES; l++) begin
          if (mtdata_q[l]) delta_q[l] <= delta_q[l] - 5'd1;
        end
      end
      sts_tap_q   <= (sts_lane < 5'(NLANES)) ? tap_q[sts_lane] : '0;
      sts_width_q <= (sts_lane < 5'(NLANES)) ? width_q[sts_lane] : '0;
    end
  end

  assign m_axis_tvalid = mtvalid_q;
  assign m_axis_tdata  = mtdata_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = done_q;
  assign fail          = fail_q;
  assign sts_tap       = sts_tap_q;
  assign sts_width     = sts_width_q;

endmodule

// File: tb/tb_axis_adc_idelay_cal.sv
// Scoreboard bench: ADC model follows the CE beats it accepts; expected beats
// are queued per run and a monitor checks each accepted beat.
module tb_axis_adc_idelay_cal;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] pattern = 14'h2A5C;
  logic        idelay_ctrl_rdy = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic [27:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        busy, done, fail;
  logic [4:0]  sts_lane = '0;
  logic [4:0]  sts_tap;
  logic [5:0]  sts_width;

  axis_adc_idelay_cal dut (
    .aclk(aclk), .areset(areset), .start(start), .pattern(pattern),
    .idelay_ctrl_rdy(idelay_ctrl_rdy), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done), .fail(fail), .sts_lane(sts_lane),
    .sts_tap(sts_tap), .sts_width(sts_width)
  );

  always #5 aclk = ~aclk;

  int          tests = 0;
  int          fails = 0;
  int          nbeats = 0;
  logic [27:0] exp_q[$];
  logic [27:0] mon_exp;
  logic [31:0] pass_tb [28];
  int          hw_tap [28];
  int          exp_center [28];
  int          exp_len [28];
  bit          gap_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: compare every accepted beat, then advance the modelled taps.
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      tests++;
      nbeats++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: got %h, required no beat", m_axis_tdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (m_axis_tdata !== mon_exp) begin
          fails++;
          $display("FAIL beat_%0d: got %h, required %h", nbeats, m_axis_tdata, mon_exp);
        end
      end
      for (int l = 0; l < 28; l++) if (m_axis_tdata[l]) hw_tap[l] = (hw_tap[l] + 1) % 32;
    end
  end

  function automatic logic [63:0] gen_word();
    logic [63:0] w;
    logic [13:0] raw;
    w = '0;
    for (int c = 0; c < 4; c++) begin
      raw = '0;
      for (int b = 0; b < 7; b++) begin
        if (pass_tb[7*c+b][hw_tap[7*c+b]]) raw[2*b +: 2] = pattern[2*b +: 2];
        else raw[2*b +: 2] = ~pattern[2*b +: 2];
      end
      w[16*c +: 16] = {2'b00, raw[13], ~raw[12:0]};
    end
    return w;
  endfunction

  always @(posedge aclk) begin
    #2;
    s_axis_tvalid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    s_axis_tdata  = gen_word();
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic datapath_reset();
    for (int l = 0; l < 28; l++) hw_tap[l] = 4;
  endtask

  // Queue 32 sweep beats, then the APPLY beats implied by the expected centres.
  task automatic push_run();
    int d [28];
    int dmax;
    logic [27:0] m;
    dmax = 0;
    for (int l = 0; l < 28; l++) begin
      d[l] = (exp_len[l] == 0) ? 0 : (exp_center[l] - 4 + 32) % 32;
      if (d[l] > dmax) dmax = d[l];
    end
    for (int k = 0; k < 32; k++) exp_q.push_back(28'hFFFFFFF);
    for (int k = 0; k < dmax; k++) begin
      m = '0;
      for (int l = 0; l < 28; l++) m[l] = d[l] > k;
      exp_q.push_back(m);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20000) begin
      cyc(1);
      n++;
    end
    chk(name, done, 1);
  endtask

  task automatic check_lane(input int l);
    int t;
    t = (exp_len[l] == 0) ? 4 : exp_center[l];
    sts_lane = 5'(l);
    cyc(2);
    chk($sformatf("sts_tap_l%0d", l), sts_tap, t);
    chk($sformatf("sts_width_l%0d", l), sts_width, exp_len[l]);
  endtask

  task automatic check_hw_taps(input string name);
    int bad;
    bad = 0;
    for (int l = 0; l < 28; l++) if (hw_tap[l] != ((exp_len[l] == 0) ? 4 : exp_center[l])) bad++;
    chk(name, bad, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_sts_tap"}, sts_tap, 0);
    chk({tag, "_sts_width"}, sts_width, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit stall_bad;
    int beats_at_stall;
    for (int l = 0; l < 28; l++) begin
      pass_tb[l] = '1;
      exp_center[l] = 15;
      exp_len[l] = 32;
    end
    datapath_reset();
    cyc(3);
    areset = 1'b0;
    cyc(1);
    check_all_zero("reset");

    // Run A: every lane passes everywhere.
    push_run();
    pulse_start();
    chk("a_busy_rise", busy, 1);
    cyc(5);
    chk("a_wait_rdy_no_beat", m_axis_tvalid, 0);
    idelay_ctrl_rdy = 1'b1;
    wait_done("a_done");
    chk("a_fail", fail, 0);
    chk("a_busy_low", busy, 0);
    chk("a_queue_empty", exp_q.size(), 0);
    check_lane(27);
    check_lane(0);
    check_hw_taps("a_hw_taps");

    // Run C: reset in the middle of a CHECK window.
    datapath_reset();
    pulse_start();
    chk("c_done_cleared", done, 0);
    cyc(40);
    areset = 1'b1;
    cyc(1);
    check_all_zero("midreset");
    areset = 1'b0;
    cyc(2);

    // Run B: mixed windows, sample gaps, a stalled STEP beat, a spurious start.
    datapath_reset();
    pass_tb[5] = 32'h000FFC00;  exp_center[5] = 14; exp_len[5] = 10;
    pass_tb[0] = 32'h00000000;  exp_center[0] = 0;  exp_len[0] = 0;
    pass_tb[3] = 32'h0FF0003C;  exp_center[3] = 23; exp_len[3] = 8;
    pass_tb[9] = 32'hF000000F;  exp_center[9] = 1;  exp_len[9] = 4;
    gap_en = 1;
    nbeats = 0;
    push_run();
    pulse_start();
    n = 0;
    while (nbeats < 5 && n < 5000) begin
      cyc(1);
      n++;
    end
    chk("b_reach_beat5", nbeats, 5);
    m_axis_tready = 1'b0;
    pulse_start();
    chk("b_start_ignored_busy", busy, 1);
    chk("b_start_ignored_done", done, 0);
    n = 0;
    while (!m_axis_tvalid && n < 1000) begin
      cyc(1);
      n++;
    end
    chk("b_stall_tvalid", m_axis_tvalid, 1);
    beats_at_stall = nbeats;
    stall_bad = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 28'hFFFFFFF) stall_bad = 1;
    end
    chk("b_stall_stable", stall_bad, 0);
    chk("b_stall_no_accept", nbeats, beats_at_stall);
    m_axis_tready = 1'b1;
    wait_done("b_done");
    chk("b_fail", fail, 1);
    chk("b_queue_empty", exp_q.size(), 0);
    chk("b_beat_total", nbeats, 32 + 29);
    check_lane(5);
    check_lane(0);
    check_lane(3);
    check_lane(9);
    check_lane(20);
    check_hw_taps("b_hw_taps");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_adc_idelay_cal.md
# axis_adc_idelay_cal

Calibration sequencer for the 4-channel, 28-lane ADC IDELAY input stage. The block steps all lane delays through the full tap range while the ADC outputs a known test pattern, and records a per-lane pass map. It then moves each lane to the centre of its longest passing window. It drives the ADC core's 28-bit per-lane CE (increment) slave stream and monitors that core's 64-bit sample output. The ADC core's IDELAYs must be built with IDELAY_TYPE "VARIABLE".

## Interface
- INIT_TAP, 4: tap value of every IDELAY after datapath reset; this is the shadow-counter start value.
- SETTLE_CYCLES, 16: wait after each CE beat before checking; minimum 8.
- SAMPLE_CYCLES, 64: valid samples compared per tap.
- MIN_WINDOW, 4: a passing window shorter than this sets `fail`.

Ports:
- aclk  in  1  single clock.
- areset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins calibration; ignored while busy.
- pattern  in  14  expected raw ADC code, identical on all channels.
- idelay_ctrl_rdy  in  1  IDELAYCTRL ready.
- s_axis_tdata  in  64  ADC samples: 4×16, channel n at [16n+15:16n], bits [12:0] inverted.
- s_axis_tvalid  in  1  sample valid.
- m_axis_tdata  out  28  per-lane CE mask; bit 7c+b is channel c, lane b.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  beat accepted.
- busy  out  1  calibration in progress.
- done  out  1  held high after completion until next start or reset.
- fail  out  1  at least one lane has a window shorter than MIN_WINDOW.
- sts_lane  in  5  lane select (0–27).
- sts_tap  out  5  final tap of the selected lane, registered, 1-cycle latency.
- sts_width  out  6  window length of the selected lane (0–32).

## Operation
- Raw reconstruction: raw[12:0] = ~tdata[12:0] and raw[13] = tdata[13] per channel. Lane b passes a sample when raw[2b+1:2b] == pattern[2b+1:2b].
- States and transitions:
  - IDLE → WAIT_RDY on `start`.
  - WAIT_RDY → SETTLE when `idelay_ctrl_rdy` is high.
  - SETTLE → CHECK after SETTLE_CYCLES.
  - CHECK → STEP after SAMPLE_CYCLES valid samples.
  - STEP → SETTLE after the beat is accepted and fewer than 32 taps have been checked; otherwise → EVAL.
  - EVAL → APPLY after all 28 lanes are scanned.
  - APPLY → DONE when every delta is 0.
  - DONE → WAIT_RDY on `start`.
- CHECK:
  - Per-lane sticky mismatch flag, cleared on entry.
  - At exit, pass[lane][shadow_tap] = ~mismatch.
  - Cycles with `s_axis_tvalid` low are not counted.
- STEP: one beat with all 28 mask bits set. The shadow tap becomes (shadow_tap + 1) mod 32. After 32 beats, the taps are back at INIT_TAP.
- EVAL, sequential, one tap per cycle per lane (896 cycles):
  - Find the longest run of consecutive passing taps over 0..31. Runs are non-circular: 31→0 does not join.
  - On a tie, take the lowest start.
  - center = start + (len−1)/2 (floor).
  - delta = (center − INIT_TAP) mod 32.
  - len = 0 gives delta = 0, and final tap = INIT_TAP.
  - len < MIN_WINDOW sets `fail`.
- APPLY: each beat sets the mask bit of every lane whose delta is nonzero, and those deltas decrement on acceptance. At most 31 beats.
- DONE: busy = 0, done = 1. `sts_*` stay valid until the next start.

## Timing
- Reset values: m_axis_tvalid 0, m_axis_tdata 0, busy 0, done 0, fail 0, sts_tap 0, sts_width 0. Pass maps and deltas are cleared and the state is IDLE.
- `busy` rises the cycle after `start` is sampled. `done` and `fail` clear on the same edge.
- AXI-S output rules:
  - tvalid and tdata are registered.
  - Once tvalid is asserted, tdata is held stable until tvalid & tready.
  - tvalid deasserts the cycle after acceptance, so there are no back-to-back beats.
- SETTLE counting starts the cycle after STEP acceptance.
- Reset mid-operation: the block returns to IDLE immediately. The hardware taps are not restored, so the datapath must be reset to INIT_TAP before the next `start`.
- `start` while busy is ignored. `start` in DONE restarts and assumes the taps are at INIT_TAP again, so the system re-resets the datapath first.

## Structure
- Package `adc_cal_pkg`:
  - state enum;
  - NLANES = 28, NTAPS = 32;
  - lane→(channel, bit) mapping function;
  - raw-reconstruction function.
- Sub-module `adc_cal_window_finder`: a sequential longest-run scanner over one 32-bit pass map. It has start and done handshakes and outputs start, len and center. It is instantiated once and time-shared across lanes in EVAL.

## Test plan
- All lanes always match, tready = 1:
  - 32 STEP beats of 0xFFFFFFF;
  - every lane len 32, center 15, delta 11;
  - 11 APPLY beats of 0xFFFFFFF;
  - done = 1, fail = 0, sts_tap = 15.
- Lane 5 passes only at taps 10..19, all others always pass: sts_lane = 5 gives sts_tap 14 and sts_width 10. Bit 5 is set in exactly 10 APPLY beats.
- Lane 0 never passes: fail = 1, sts_width 0, sts_tap 4, and bit 0 is never set during APPLY.
- Lane 3 passes at taps 2..5 and 20..27: window 20..27, center 23. A wrap case passing at 28..31 and 0..3 gives len 4, start 0, center 1.
- tready held low for 10 cycles on a STEP beat: tdata and tvalid stay stable, the beat counts once, and exactly 32 STEP beats occur in total.
- areset during CHECK: all outputs 0 the next cycle. A `start` during busy has no effect, and `s_axis_tvalid` gaps extend CHECK by the gap length.
